// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: handshaked 2-entry skid pipeline register with flush and optional PIPE_STAGE_PERF_EN counters
module pipe_stage_skid #(
  parameter int DATA_W = 160,
  parameter int CTRL_W = 16
`ifdef PIPE_STAGE_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  input  logic [CTRL_W-1:0] up_ctrl_i,
  input  logic              flush_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [CTRL_W-1:0] dn_ctrl_o,
  output logic [1:0]        occupancy_o
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt_o
  , output logic [CNT_W-1:0] bubble_cnt_o
`endif
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, next;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic up_fire, dn_fire, ld_main, ld_skid;
  assign dn_valid_o  = state != EMPTY;
  assign dn_data_o   = main_data;
  assign dn_ctrl_o   = dn_valid_o ? main_ctrl : '0;
  assign occupancy_o = state;
  assign up_fire     = up_valid_i & up_ready_o;
  assign dn_fire     = dn_valid_o & dn_ready_i;
  always_comb begin
    next    = state;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    case (state)
      EMPTY: begin
        next    = up_fire ? ONE : EMPTY;
        ld_main = up_fire;
      end
      ONE: begin
        next    = (up_fire & ~dn_fire) ? TWO : (dn_fire & ~up_fire) ? EMPTY : ONE;
        ld_main = up_fire & dn_fire;
        ld_skid = up_fire & ~dn_fire;
      end
      TWO: begin
        next    = dn_fire ? ONE : TWO;
        ld_main = dn_fire;
      end
      default: next = EMPTY;
    endcase
    if (flush_i) begin
      next    = EMPTY;
      ld_main = 1'b0;
      ld_skid = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= EMPTY;
      up_ready_o <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else begin
      state      <= next;
      up_ready_o <= next != TWO;
      if (ld_main) begin
        main_data <= state == TWO ? skid_data : up_data_i;
        main_ctrl <= state == TWO ? skid_ctrl : up_ctrl_i;
      end
      if (ld_skid) begin
        skid_data <= up_data_i;
        skid_ctrl <= up_ctrl_i;
      end
    end
  end
`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (dn_valid_o & ~dn_ready_i & ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (~dn_valid_o & ~&bubble_cnt_o) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: table-driven check of pipe_stage_skid handshake, skid, flush, reset and PIPE_STAGE_PERF_EN counters
module tb_pipe_stage_skid;
  localparam int DW = 16;
  localparam int CW = 4;
  logic clk = 1'b0, reset = 1'b0, up_valid_i = 1'b0, flush_i = 1'b0, dn_ready_i = 1'b0;
  logic up_ready_o, dn_valid_o;
  logic [DW-1:0] up_data_i = '0, dn_data_o;
  logic [CW-1:0] up_ctrl_i = '0, dn_ctrl_o;
  logic [1:0] occupancy_o;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0] stall_cnt_o, bubble_cnt_o;
`endif
  int checks = 0, errors = 0;
  typedef struct {
    logic uv; logic [DW-1:0] ud; logic [CW-1:0] uc; logic fl; logic dr;
    logic ev; logic [DW-1:0] ed; logic [CW-1:0] ec; logic [1:0] eo; logic er;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .up_valid_i(up_valid_i), .up_ready_o(up_ready_o),
    .up_data_i(up_data_i), .up_ctrl_i(up_ctrl_i), .flush_i(flush_i),
    .dn_valid_o(dn_valid_o), .dn_ready_i(dn_ready_i), .dn_data_o(dn_data_o),
    .dn_ctrl_o(dn_ctrl_o), .occupancy_o(occupancy_o)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic uv, input logic [DW-1:0] ud, input logic [CW-1:0] uc, input logic fl, input logic dr);
    up_valid_i = uv;
    up_data_i  = ud;
    up_ctrl_i  = uc;
    flush_i    = fl;
    dn_ready_i = dr;
  endtask
  initial begin
    for (int i = 0; i < 8; i++)
      tbl.push_back(vec_t'{1'b1, DW'(16'h10 + i), CW'(i + 1), 1'b0, 1'b1, 1'b1, DW'(16'h10 + i), CW'(i + 1), 2'd1, 1'b1});
    tbl.push_back(vec_t'{1'b0, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0017, 4'd0, 2'd0, 1'b1});
    tbl.push_back(vec_t'{1'b1, 16'h0020, 4'd5, 1'b0, 1'b0, 1'b1, 16'h0020, 4'd5, 2'd1, 1'b1});
    tbl.push_back(vec_t'{1'b1, 16'h0021, 4'd6, 1'b0, 1'b0, 1'b1, 16'h0020, 4'd5, 2'd2, 1'b0});
    tbl.push_back(vec_t'{1'b1, 16'h0022, 4'd7, 1'b0, 1'b0, 1'b1, 16'h0020, 4'd5, 2'd2, 1'b0});
    tbl.push_back(vec_t'{1'b1, 16'h0022, 4'd7, 1'b0, 1'b1, 1'b1, 16'h0021, 4'd6, 2'd1, 1'b1});
    tbl.push_back(vec_t'{1'b1, 16'h0022, 4'd7, 1'b0, 1'b1, 1'b1, 16'h0022, 4'd7, 2'd1, 1'b1});
    tbl.push_back(vec_t'{1'b0, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0022, 4'd0, 2'd0, 1'b1});
    tbl.push_back(vec_t'{1'b1, 16'h0030, 4'd1, 1'b0, 1'b0, 1'b1, 16'h0030, 4'd1, 2'd1, 1'b1});
    tbl.push_back(vec_t'{1'b1, 16'h0031, 4'd2, 1'b0, 1'b0, 1'b1, 16'h0030, 4'd1, 2'd2, 1'b0});
    tbl.push_back(vec_t'{1'b1, 16'h0032, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0030, 4'd0, 2'd0, 1'b1});
    tbl.push_back(vec_t'{1'b0, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0030, 4'd0, 2'd0, 1'b1});
    tbl.push_back(vec_t'{1'b1, 16'h0033, 4'd4, 1'b0, 1'b0, 1'b1, 16'h0033, 4'd4, 2'd1, 1'b1});
    tbl.push_back(vec_t'{1'b1, 16'h0034, 4'd5, 1'b1, 1'b1, 1'b0, 16'h0033, 4'd0, 2'd0, 1'b1});
    tbl.push_back(vec_t'{1'b0, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0033, 4'd0, 2'd0, 1'b1});
    reset = 1'b0;
    step();
    step();
    chk("rst_up_ready", up_ready_o, 0);
    chk("rst_dn_valid", dn_valid_o, 0);
    chk("rst_dn_data", dn_data_o, 0);
    chk("rst_dn_ctrl", dn_ctrl_o, 0);
    chk("rst_occ", occupancy_o, 0);
`ifdef PIPE_STAGE_PERF_EN
    chk("rst_stall_cnt", stall_cnt_o, 0);
    chk("rst_bubble_cnt", bubble_cnt_o, 0);
`endif
    reset = 1'b1;
    #1;
    chk("ready_low_before_edge", up_ready_o, 0);
    step();
    chk("ready_after_release", up_ready_o, 1);
    drive(1'b1, 16'h0010, 4'd1, 1'b0, 1'b1);
    #1;
    chk("first_cycle_ctrl", dn_ctrl_o, 0);
    chk("first_cycle_valid", dn_valid_o, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].uv, tbl[i].ud, tbl[i].uc, tbl[i].fl, tbl[i].dr);
      step();
      chk($sformatf("vec%0d_valid", i), dn_valid_o, tbl[i].ev);
      chk($sformatf("vec%0d_data", i), dn_data_o, tbl[i].ed);
      chk($sformatf("vec%0d_ctrl", i), dn_ctrl_o, tbl[i].ec);
      chk($sformatf("vec%0d_occ", i), occupancy_o, tbl[i].eo);
      chk($sformatf("vec%0d_ready", i), up_ready_o, tbl[i].er);
    end
    drive(1'b1, 16'h0040, 4'd1, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0041, 4'd2, 1'b0, 1'b0);
    step();
    chk("prefill_occ", occupancy_o, 2);
    reset = 1'b0;
    drive(1'b1, 16'h0042, 4'd3, 1'b1, 1'b1);
    step();
    chk("midrst_up_ready", up_ready_o, 0);
    chk("midrst_dn_valid", dn_valid_o, 0);
    chk("midrst_dn_data", dn_data_o, 0);
    chk("midrst_dn_ctrl", dn_ctrl_o, 0);
    chk("midrst_occ", occupancy_o, 0);
    reset = 1'b1;
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    step();
    chk("midrst_release_ready", up_ready_o, 1);
    chk("midrst_release_occ", occupancy_o, 0);
    chk("midrst_release_valid", dn_valid_o, 0);
`ifdef PIPE_STAGE_PERF_EN
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("perf_bubble_idle", bubble_cnt_o, 1);
    drive(1'b1, 16'h0050, 4'd9, 1'b0, 1'b0);
    step();
    drive(1'b0, 16'h0000, 4'd0, 1'b0, 1'b0);
    repeat (20) step();
    chk("perf_stall_sat", stall_cnt_o, 15);
    chk("perf_bubble_hold", bubble_cnt_o, 2);
    chk("perf_valid_held", dn_valid_o, 1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("perf_stall_after_flush", stall_cnt_o, 15);
    chk("perf_bubble_after_flush", bubble_cnt_o, 2);
    step();
    chk("perf_bubble_resume", bubble_cnt_o, 3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
